// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage in front of a 16-bit ALU: fetches operands from an 8x16
// register file, drives the ALU for one cycle, writes back the result and a zero flag.
module alu_issue_ctrl #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_fs,
  input  logic [DW-1:0] alu_result,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          zflag,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  state_e        r_state;
  state_e        w_state_nxt;

  logic [15:0]   r_instr;
  logic [DW-1:0] r_res;
  logic [DW-1:0] r_regs [NREG];
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic [3:0]    r_alu_fs;
  logic          r_zflag;

  logic [3:0]    w_fs;
  logic [AW-1:0] w_rd;
  logic [AW-1:0] w_ra;
  logic [AW-1:0] w_rb;
  logic          w_accept;
  logic          w_nop;
  logic          w_wb_we;

  // instr[2:0] is a reserved field with no function in this stage.
  logic          w_unused_instr_bits;
  assign w_unused_instr_bits = ^r_instr[2:0];

  assign w_fs = r_instr[15:12];
  assign w_rd = r_instr[9 +: AW];
  assign w_ra = r_instr[6 +: AW];
  assign w_rb = r_instr[3 +: AW];

  // Function selects with no architectural result: skip the write and keep zflag.
  always_comb begin
    w_nop = 1'b0;
    case (w_fs)
      4'b1000, 4'b1001, 4'b1010, 4'b1101, 4'b1110: w_nop = 1'b1;
      default:                                     w_nop = 1'b0;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && instr_valid;
  assign w_wb_we  = (r_state == S_WB) && !w_nop;

  // State register.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment up front keeps this block from inferring a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (instr_valid) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      S_WB:    done = 1'b1;
      default: ;
    endcase
  end

  // Instruction latch, ALU operand registers, result capture and zero flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr  <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_fs <= '0;
      r_res    <= '0;
      r_zflag  <= 1'b0;
    end else begin
      if (w_accept) r_instr <= instr;
      if (r_state == S_READ) begin
        r_alu_a  <= r_regs[w_ra];
        r_alu_b  <= r_regs[w_rb];
        r_alu_fs <= w_fs;
      end
      if (r_state == S_EXEC) r_res <= alu_result;
      if (w_wb_we) r_zflag <= (r_res == '0);
    end
  end

  // Register file: external load port plus writeback port.
  // NOTE: the register array is reset because an asynchronous clear of every entry is part of
  // the block's contract; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (ld_en) r_regs[ld_addr] <= ld_data;
      // Writeback is assigned last so it overrides a load to the same register on this edge.
      if (w_wb_we) r_regs[w_rd] <= r_res;
    end
  end

  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_fs  = r_alu_fs;
  assign zflag   = r_zflag;
  assign rd_data = r_regs[rd_addr];

endmodule
